scale_ctrl: RTL and testbench

SCALE_CTRL -- requirements
Module: scale_ctrl

---
 rtl/scale_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_scale_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_ctrl.sv
// scale_ctrl: horizontal scaler control. It computes the source step per output
// sample with a serial restoring divider. For each accepted source pixel it then
// presents the left/right neighbour pixels and their blend weights to a
// downstream weighting unit.
//
// Optional build macro: SCALE_CTRL_BYPASS_EN. When it is defined, equal source
// and destination widths skip the divider and pass each pixel through as
// a=b=pix_in.
//
// Ports:
//   sys_clk, sys_rst_n      clock, synchronous active-low reset
//   cfg_src_w, cfg_dst_w    source / destination pixels per line
//   cfg_load                pulse: latch widths, start step computation
//   line_start              pulse: begin (or restart) a line
//   pix_valid, pix_in       source pixel stream
//   a, b, a_coff, b_coff    registered sample for the weighting unit
//   data_en                 registered copy of an accepted pix_valid
//   scale_en                a/b/coff hold a new output sample
//   busy                    dividing or inside a line
//   cfg_err                 sticky, last load was invalid
//   line_done               pulses with the outputs of the last source pixel
//
// state | meaning
// IDLE  | no valid configuration
// DIV   | computing step = floor(src_w*256/dst_w), one bit per cycle
// READY | step valid, waiting for line_start
// LINE  | consuming source pixels of a line
module scale_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int W_BITS     = 12
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [W_BITS-1:0]     cfg_src_w,
  input  logic [W_BITS-1:0]     cfg_dst_w,
  input  logic                  cfg_load,
  input  logic                  line_start,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [7:0]            a_coff,
  output logic [7:0]            b_coff,
  output logic                  data_en,
  output logic                  scale_en,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  line_done
);

  localparam int PH_W  = W_BITS + 8;
  localparam int CNT_W = $clog2(PH_W + 1);
  localparam logic [CNT_W-1:0]  DIV_CYC = CNT_W'(PH_W);
  localparam logic [W_BITS-1:0] W_TWO   = W_BITS'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_READY = 2'd2,
    S_LINE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [W_BITS-1:0]     r_src_w;
  logic [W_BITS-1:0]     r_dst_w;
  logic [PH_W-1:0]       r_step;
  logic [PH_W-1:0]       r_dvd;
  logic [W_BITS-1:0]     r_rem;
  logic [CNT_W-1:0]      r_div_cnt;
  logic [W_BITS-1:0]     r_in_cnt;
  logic [W_BITS:0]       r_out_cnt;
  logic [PH_W-1:0]       r_phase;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [7:0]            r_a_coff;
  logic [7:0]            r_b_coff;
  logic                  r_data_en;
  logic                  r_scale_en;
  logic                  r_busy;
  logic                  r_cfg_err;
  logic                  r_line_done;
`ifdef SCALE_CTRL_BYPASS_EN
  logic                  r_bypass;
`endif

  // Restoring divider: the dividend shifts out MSB first and quotient bits
  // shift in at the bottom, so r_dvd ends up holding the quotient.
  logic [W_BITS:0]   w_trial;
  logic              w_qbit;
  logic [W_BITS-1:0] w_rem_nxt;

  assign w_trial   = {r_rem, r_dvd[PH_W-1]};
  assign w_qbit    = (w_trial >= {1'b0, r_dst_w});
  assign w_rem_nxt = w_qbit ? (w_trial[W_BITS-1:0] - r_dst_w) : w_trial[W_BITS-1:0];

  logic w_cfg_bad;
  assign w_cfg_bad = (cfg_dst_w == '0) || (cfg_dst_w > cfg_src_w) || (cfg_src_w < W_TWO);

  // A line_start pixel is pixel 0 of the new line, so counters are
  // substituted with zero before the emit decision.
  logic              w_restart;
  logic              w_accept;
  logic [W_BITS-1:0] w_cnt;
  logic [W_BITS:0]   w_ocnt;
  logic [PH_W-1:0]   w_phase;
  logic [W_BITS-1:0] w_int;
  logic [7:0]        w_frac;
  logic [W_BITS:0]   w_int_p1;
  logic [W_BITS-1:0] w_src_m1;
  logic              w_last;
  logic              w_emit_n;
  logic              w_emit_e;
  logic              w_emit_b;

  assign w_restart = line_start && ((r_state == S_READY) || (r_state == S_LINE));
  assign w_accept  = pix_valid && (w_restart || (r_state == S_LINE));
  assign w_cnt     = w_restart ? '0 : r_in_cnt;
  assign w_ocnt    = w_restart ? '0 : r_out_cnt;
  assign w_phase   = w_restart ? '0 : r_phase;
  assign w_int     = w_phase[PH_W-1:8];
  assign w_frac    = w_phase[7:0];
  assign w_int_p1  = {1'b0, w_int} + {{W_BITS{1'b0}}, 1'b1};
  assign w_src_m1  = r_src_w - W_BITS'(1);
  assign w_last    = (w_cnt == w_src_m1);
  assign w_emit_n  = (w_ocnt < {1'b0, r_dst_w}) && ({1'b0, w_cnt} == w_int_p1);
  assign w_emit_e  = w_last && (w_int >= w_src_m1);
`ifdef SCALE_CTRL_BYPASS_EN
  assign w_emit_b  = r_bypass;
`else
  assign w_emit_b  = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_src_w     <= '0;
      r_dst_w     <= '0;
      r_step      <= '0;
      r_dvd       <= '0;
      r_rem       <= '0;
      r_div_cnt   <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_phase     <= '0;
      r_prev      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_a_coff    <= '0;
      r_b_coff    <= '0;
      r_data_en   <= 1'b0;
      r_scale_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_line_done <= 1'b0;
`ifdef SCALE_CTRL_BYPASS_EN
      r_bypass    <= 1'b0;
`endif
    end else begin
      r_data_en   <= 1'b0;
      r_scale_en  <= 1'b0;
      r_line_done <= 1'b0;

      if (cfg_load && (r_state != S_LINE)) begin
        r_src_w   <= cfg_src_w;
        r_dst_w   <= cfg_dst_w;
        r_cfg_err <= 1'b0;
`ifdef SCALE_CTRL_BYPASS_EN
        r_bypass  <= 1'b0;
`endif
        if (w_cfg_bad) begin
          r_cfg_err <= 1'b1;
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
        end
`ifdef SCALE_CTRL_BYPASS_EN
        else if (cfg_src_w == cfg_dst_w) begin
          r_bypass <= 1'b1;
          r_step   <= PH_W'(256);
          r_state  <= S_READY;
          r_busy   <= 1'b0;
        end
`endif
        else begin
          r_rem     <= '0;
          r_dvd     <= {cfg_src_w, 8'h00};
          r_div_cnt <= DIV_CYC;
          r_state   <= S_DIV;
          r_busy    <= 1'b1;
        end
      end else begin
        case (r_state)
          S_DIV: begin
            r_rem <= w_rem_nxt;
            r_dvd <= {r_dvd[PH_W-2:0], w_qbit};
            if (r_div_cnt == CNT_W'(1)) begin
              r_step    <= {r_dvd[PH_W-2:0], w_qbit};
              r_div_cnt <= '0;
              r_state   <= S_READY;
              r_busy    <= 1'b0;
            end else begin
              r_div_cnt <= r_div_cnt - CNT_W'(1);
            end
          end
          S_READY, S_LINE: begin
            if (w_restart) begin
              r_in_cnt  <= '0;
              r_out_cnt <= '0;
              r_phase   <= '0;
              r_state   <= S_LINE;
              r_busy    <= 1'b1;
            end
            // Pixel handling overrides the restart clears above.
            if (w_accept) begin
              r_data_en <= 1'b1;
              r_prev    <= pix_in;
              r_in_cnt  <= w_cnt + W_BITS'(1);
              if (w_emit_b || w_emit_n || w_emit_e) begin
                r_scale_en <= 1'b1;
                r_phase    <= w_phase + r_step;
                r_out_cnt  <= w_ocnt + (W_BITS+1)'(1);
              end
              if (w_emit_b || (!w_emit_n && w_emit_e)) begin
                r_a      <= pix_in;
                r_b      <= pix_in;
                r_a_coff <= 8'hFF;
                r_b_coff <= 8'h00;
              end else if (w_emit_n) begin
                r_a      <= r_prev;
                r_b      <= pix_in;
                r_a_coff <= ~w_frac;
                r_b_coff <= w_frac;
              end
              if (w_last) begin
                r_line_done <= 1'b1;
                r_state     <= S_READY;
                r_busy      <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign a_coff    = r_a_coff;
  assign b_coff    = r_b_coff;
  assign data_en   = r_data_en;
  assign scale_en  = r_scale_en;
  assign busy      = r_busy;
  assign cfg_err   = r_cfg_err;
  assign line_done = r_line_done;

endmodule

// File: tb/tb_scale_ctrl.sv
module tb_scale_ctrl;

  localparam int DW = 8;
  localparam int WB = 12;
  localparam int N_CFG  = 5;
  localparam int N_EMIT = 17;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [WB-1:0] cfg_src_w;
  logic [WB-1:0] cfg_dst_w;
  logic          cfg_load;
  logic          line_start;
  logic          pix_valid;
  logic [DW-1:0] pix_in;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [7:0]    a_coff;
  logic [7:0]    b_coff;
  logic          data_en;
  logic          scale_en;
  logic          busy;
  logic          cfg_err;
  logic          line_done;

  scale_ctrl #(.DATA_WIDTH(DW), .W_BITS(WB)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cfg_src_w  (cfg_src_w),
    .cfg_dst_w  (cfg_dst_w),
    .cfg_load   (cfg_load),
    .line_start (line_start),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .a          (a),
    .b          (b),
    .a_coff     (a_coff),
    .b_coff     (b_coff),
    .data_en    (data_en),
    .scale_en   (scale_en),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .line_done  (line_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int src;
    int dst;
  } cfg_t;

  // One record per expected output sample: config, source pixel index at which
  // it appears, pixel indices presented on a and b, and b_coff.
  typedef struct {
    int         cfg;
    int         k;
    int         ai;
    int         bi;
    logic [7:0] bc;
  } emit_t;

  cfg_t  cfgs [N_CFG];
  emit_t emit_tab [N_EMIT];

  int n_pass = 0;
  int n_chk  = 0;

  // Expected held output values, updated whenever a sample is expected.
  logic [7:0] h_a, h_b, h_ac, h_bc;

  function automatic logic [7:0] pix(input int k);
    return 8'(33 + k * 29);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " a"},         32'(a), 0);
    chk({tag, " b"},         32'(b), 0);
    chk({tag, " a_coff"},    32'(a_coff), 0);
    chk({tag, " b_coff"},    32'(b_coff), 0);
    chk({tag, " data_en"},   32'(data_en), 0);
    chk({tag, " scale_en"},  32'(scale_en), 0);
    chk({tag, " busy"},      32'(busy), 0);
    chk({tag, " cfg_err"},   32'(cfg_err), 0);
    chk({tag, " line_done"}, 32'(line_done), 0);
  endtask

  task automatic load(input int src, input int dst);
    cfg_src_w = WB'(src);
    cfg_dst_w = WB'(dst);
    cfg_load  = 1'b1;
    tick();
    cfg_load  = 1'b0;
  endtask

  function automatic int div_cycles(input int src, input int dst);
`ifdef SCALE_CTRL_BYPASS_EN
    if (src == dst) return 0;
`endif
    return 20;
  endfunction

  task automatic wait_div(input string tag, input int exp_n);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk({tag, " busy cycles"}, 32'(n), 32'(exp_n));
  endtask

  task automatic run_line(input int c, input int npix, input bit combined, input int load_k);
    int  src;
    bit  byp;
    bit  se;
    int  ai, bi;
    logic [7:0] bc;
    src = cfgs[c].src;
`ifdef SCALE_CTRL_BYPASS_EN
    byp = (cfgs[c].src == cfgs[c].dst);
`else
    byp = 1'b0;
`endif
    if (!combined) begin
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      chk($sformatf("c%0d start busy", c), 32'(busy), 1);
    end
    for (int k = 0; k < npix; k++) begin
      line_start = combined && (k == 0);
      pix_valid  = 1'b1;
      pix_in     = pix(k);
      if (k == load_k) begin
        cfg_src_w = 12'd8;
        cfg_dst_w = 12'd2;
        cfg_load  = 1'b1;
      end
      tick();
      line_start = 1'b0;
      pix_valid  = 1'b0;
      cfg_load   = 1'b0;
      se = 1'b0; ai = 0; bi = 0; bc = 8'h00;
      if (byp) begin
        se = 1'b1; ai = k; bi = k;
      end else begin
        for (int i = 0; i < N_EMIT; i++) begin
          if (emit_tab[i].cfg == c && emit_tab[i].k == k) begin
            se = 1'b1;
            ai = emit_tab[i].ai;
            bi = emit_tab[i].bi;
            bc = emit_tab[i].bc;
          end
        end
      end
      if (se) begin
        h_a  = pix(ai);
        h_b  = pix(bi);
        h_bc = bc;
        h_ac = ~bc;
      end
      chk($sformatf("c%0d k%0d data_en", c, k),   32'(data_en), 1);
      chk($sformatf("c%0d k%0d scale_en", c, k),  32'(scale_en), 32'(se));
      chk($sformatf("c%0d k%0d line_done", c, k), 32'(line_done), 32'(k == src - 1));
      chk($sformatf("c%0d k%0d busy", c, k),      32'(busy), 32'(k != src - 1));
      chk($sformatf("c%0d k%0d a", c, k),         32'(a), 32'(h_a));
      chk($sformatf("c%0d k%0d b", c, k),         32'(b), 32'(h_b));
      chk($sformatf("c%0d k%0d a_coff", c, k),    32'(a_coff), 32'(h_ac));
      chk($sformatf("c%0d k%0d b_coff", c, k),    32'(b_coff), 32'(h_bc));
    end
  endtask

  task automatic idle_check(input string tag);
    tick();
    chk({tag, " idle data_en"},   32'(data_en), 0);
    chk({tag, " idle scale_en"},  32'(scale_en), 0);
    chk({tag, " idle line_done"}, 32'(line_done), 0);
    chk({tag, " idle a"},         32'(a), 32'(h_a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cfgs[0] = '{8, 4};
    cfgs[1] = '{6, 4};
    cfgs[2] = '{4, 4};
    cfgs[3] = '{5, 2};
    cfgs[4] = '{5, 3};

    // src=8 dst=4, step 0x200
    emit_tab[0]  = '{0, 1, 0, 1, 8'h00};
    emit_tab[1]  = '{0, 3, 2, 3, 8'h00};
    emit_tab[2]  = '{0, 5, 4, 5, 8'h00};
    emit_tab[3]  = '{0, 7, 6, 7, 8'h00};
    // src=6 dst=4, step 0x180
    emit_tab[4]  = '{1, 1, 0, 1, 8'h00};
    emit_tab[5]  = '{1, 2, 1, 2, 8'h80};
    emit_tab[6]  = '{1, 4, 3, 4, 8'h00};
    emit_tab[7]  = '{1, 5, 4, 5, 8'h80};
    // src=dst=4, step 0x100; the last pixel already carries a regular emit
    emit_tab[8]  = '{2, 1, 0, 1, 8'h00};
    emit_tab[9]  = '{2, 2, 1, 2, 8'h00};
    emit_tab[10] = '{2, 3, 2, 3, 8'h00};
    // src=5 dst=2, step 0x280; phase jumps past the last pixel -> edge emit
    emit_tab[11] = '{3, 1, 0, 1, 8'h00};
    emit_tab[12] = '{3, 3, 2, 3, 8'h80};
    emit_tab[13] = '{3, 4, 4, 4, 8'h00};
    // src=5 dst=3, step 0x1AA
    emit_tab[14] = '{4, 1, 0, 1, 8'h00};
    emit_tab[15] = '{4, 2, 1, 2, 8'hAA};
    emit_tab[16] = '{4, 4, 3, 4, 8'h54};

    sys_rst_n  = 1'b0;
    cfg_src_w  = '0;
    cfg_dst_w  = '0;
    cfg_load   = 1'b0;
    line_start = 1'b0;
    pix_valid  = 1'b0;
    pix_in     = '0;
    h_a = 8'h00; h_b = 8'h00; h_ac = 8'h00; h_bc = 8'h00;
    tick();
    tick();
    chk_all_zero("reset");
    sys_rst_n = 1'b1;

    // Pixels are ignored before any configuration.
    line_start = 1'b1; pix_valid = 1'b1; pix_in = 8'h5A;
    tick();
    line_start = 1'b0; pix_valid = 1'b0;
    chk("idle pix data_en", 32'(data_en), 0);
    chk("idle pix busy",    32'(busy), 0);

    // Invalid configurations.
    load(8, 0);
    chk("dst0 cfg_err", 32'(cfg_err), 1);
    chk("dst0 busy",    32'(busy), 0);
    load(8, 9);
    chk("dst>src cfg_err", 32'(cfg_err), 1);
    chk("dst>src busy",    32'(busy), 0);
    load(1, 1);
    chk("src<2 cfg_err", 32'(cfg_err), 1);
    line_start = 1'b1; pix_valid = 1'b1;
    tick();
    line_start = 1'b0; pix_valid = 1'b0;
    chk("err pix data_en", 32'(data_en), 0);

    // Valid load clears the error; 8 -> 4.
    load(8, 4);
    chk("valid cfg_err clear", 32'(cfg_err), 0);
    chk("valid busy",          32'(busy), 1);
    wait_div("c0", 20);
    run_line(0, 8, 1'b0, -1);
    idle_check("c0");

    // Mid-line restart at pixel 5, then a full line.
    run_line(0, 5, 1'b0, -1);
    run_line(0, 8, 1'b1, -1);
    idle_check("c0 restart");

    // A second load during DIV restarts the division; a load inside LINE is ignored.
    load(8, 4);
    repeat (5) tick();
    load(6, 4);
    wait_div("c1 div restart", 20);
    run_line(1, 6, 1'b1, 2);
    idle_check("c1");

    load(4, 4);
    wait_div("c2", div_cycles(4, 4));
    run_line(2, 4, 1'b0, -1);
    idle_check("c2");

    load(5, 2);
    wait_div("c3", 20);
    run_line(3, 5, 1'b1, -1);
    idle_check("c3");

    load(5, 3);
    wait_div("c4", 20);
    run_line(4, 5, 1'b0, -1);
    idle_check("c4");

    // Reset at pixel 3 of an 8-pixel line.
    load(8, 4);
    wait_div("c0 pre-reset", 20);
    run_line(0, 3, 1'b1, -1);
    pix_valid = 1'b1;
    pix_in    = pix(3);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b0;
    pix_valid = 1'b0;
    chk_all_zero("midline reset");
    h_a = 8'h00; h_b = 8'h00; h_ac = 8'h00; h_bc = 8'h00;
    sys_rst_n = 1'b1;
    line_start = 1'b1; pix_valid = 1'b1; pix_in = pix(0);
    tick();
    line_start = 1'b0;
    chk("post-reset data_en", 32'(data_en), 0);
    tick();
    pix_valid = 1'b0;
    chk("post-reset data_en 2", 32'(data_en), 0);
    chk("post-reset busy",      32'(busy), 0);
    load(8, 4);
    wait_div("c0 post-reset", 20);
    run_line(0, 8, 1'b1, -1);
    idle_check("c0 post-reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
